// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings and default widths for the SRAM port arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2
    } arb_op_e;

    localparam int SRAM_ADDR_W = 20;
    localparam int PIX_W       = 8;

endpackage

// File: rtl/sram_port_arbiter_wr_fifo.sv
// Synchronous write-buffer FIFO; push is refused while full even if a pop
// happens in the same cycle.
module sram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram_conn port between VGA pixel reads and buffered
// framebuffer-copy writes; reads win unless the write queue starves.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = PIX_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int RD_LAT       = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cp_valid,
    input  logic [ADDR_W-1:0]             cp_addr,
    input  logic [DATA_W-1:0]             cp_data,
    output logic                          cp_ready,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          rd_late,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int FW = ADDR_W + DATA_W;

    arb_op_e             r_op;
    arb_op_e             w_op_nxt;
    logic [SW-1:0]       r_starve;
    logic                r_pend_v;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic                r_late;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [RD_LAT-1:0]   r_vsh;
    logic [DATA_W-1:0]   r_rd_data;

    logic [FW-1:0]       w_fifo_dout;
    logic                w_full;
    logic                w_empty;
    logic                w_force;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [RD_LAT:0]     w_tap;

    sram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (cp_valid),
        .i_din   ({cp_addr, cp_data}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_force   = (r_starve == SW'(STARVE_LIMIT)) & ~w_empty & ~r_pend_v;
    assign w_rd_addr = r_pend_v ? r_pend_addr : rd_addr;
    assign w_pop     = (w_op_nxt == ARB_WRITE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= ARB_IDLE;
        end else begin
            r_op <= w_op_nxt;
        end
    end

    always_comb begin
        w_op_nxt = ARB_IDLE;
        if (w_force) begin
            w_op_nxt = ARB_WRITE;
        end else if (r_pend_v | rd_req) begin
            w_op_nxt = ARB_READ;
        end else if (!w_empty) begin
            w_op_nxt = ARB_WRITE;
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (r_op)
            ARB_READ:  mem_read  = 1'b1;
            ARB_WRITE: mem_write = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_op_nxt == ARB_READ) begin
            r_addr <= w_rd_addr;
        end else if (w_op_nxt == ARB_WRITE) begin
            r_addr  <= w_fifo_dout[DATA_W +: ADDR_W];
            r_wdata <= w_fifo_dout[DATA_W-1:0];
        end
    end

    // One-deep skid: a forced write parks the read, and a served pending
    // read is replaced by any request arriving in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_late      <= 1'b0;
        end else begin
            r_late <= w_force & rd_req;
            if (w_force | r_pend_v) begin
                r_pend_v <= rd_req;
                if (rd_req) begin
                    r_pend_addr <= rd_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_empty || w_op_nxt == ARB_WRITE) begin
            r_starve <= '0;
        end else if (r_starve != SW'(STARVE_LIMIT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign w_tap = {r_vsh, mem_read};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsh     <= '0;
            r_rd_data <= '0;
        end else begin
            r_vsh <= w_tap[RD_LAT-1:0];
            if (w_tap[RD_LAT-1]) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign rd_valid  = w_tap[RD_LAT];
    assign rd_data   = r_rd_data;
    assign rd_late   = r_late;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cp_ready  = ~w_full;
    assign busy      = ~w_empty | r_pend_v | (|w_tap[RD_LAT-1:0]);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed table, corner sequences and
// random traffic against a rule-level arbitration and SRAM model.
module tb_sram_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cp_valid = 1'b0;
    logic [19:0] cp_addr = '0;
    logic [7:0]  cp_data = '0;
    logic        cp_ready;
    logic        rd_req = 1'b0;
    logic [19:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_late;
    logic        mem_read;
    logic        mem_write;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [2:0]  fifo_count;
    logic        busy;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cp_valid   (cp_valid),
        .cp_addr    (cp_addr),
        .cp_data    (cp_data),
        .cp_ready   (cp_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_late    (rd_late),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];

    typedef struct {
        logic [19:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         mq[$];
    bit          m_pend;
    logic [19:0] m_paddr;
    int          m_starve;
    bit          m_mr, m_mw, m_late, m_rv;
    logic [19:0] m_addr;
    logic [7:0]  m_wd, m_rd;

    typedef struct {
        bit          rq;
        logic [19:0] ra;
        bit          cv;
        logic [19:0] ca;
        logic [7:0]  cd;
        bit          e_mr, e_mw;
        logic [19:0] e_a;
        logic [7:0]  e_wd;
        int          e_cnt;
        bit          e_rdy, e_rv;
        logic [7:0]  e_rd;
        bit          e_late;
    } vec_t;

    function automatic logic [7:0] f_init(input logic [19:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string nm, input int unsigned act,
                       input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, ncyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_paddr = '0; m_starve = 0;
        m_mr = 0; m_mw = 0; m_late = 0; m_rv = 0;
        m_addr = '0; m_wd = '0; m_rd = '0;
    endtask

    // Arbitration rules applied to one clock edge.
    task automatic model_edge(input bit rq, input logic [19:0] ra,
                              input bit cv, input logic [19:0] ca,
                              input logic [7:0] cd);
        bit  ne = (mq.size() != 0);
        bit  push = cv && (mq.size() < DEPTH);
        bit  n_mr = 0, n_mw = 0;
        wr_t e;
        m_rv = m_mr;
        if (m_mr) m_rd = ref_mem[m_addr[7:0]];
        if (m_mw) ref_mem[m_addr[7:0]] = m_wd;
        m_late = 0;
        if (ne && m_starve == LIM && !m_pend) begin
            n_mw = 1;
            e = mq.pop_front();
            m_addr = e.a; m_wd = e.d;
            if (rq) begin m_pend = 1; m_paddr = ra; m_late = 1; end
        end else if (m_pend || rq) begin
            n_mr = 1;
            m_addr = m_pend ? m_paddr : ra;
            if (m_pend) begin
                if (rq) m_paddr = ra;
                else m_pend = 0;
            end
        end else if (ne) begin
            n_mw = 1;
            e = mq.pop_front();
            m_addr = e.a; m_wd = e.d;
        end
        if (!ne || n_mw) m_starve = 0;
        else if (m_starve < LIM) m_starve++;
        if (push) begin
            e.a = ca; e.d = cd;
            mq.push_back(e);
        end
        m_mr = n_mr; m_mw = n_mw;
    endtask

    task automatic cyc(input bit rq, input logic [19:0] ra, input bit cv,
                       input logic [19:0] ca, input logic [7:0] cd);
        bit          pre_mw;
        logic [19:0] pre_a;
        logic [7:0]  pre_d;
        @(negedge clk);
        rd_req = rq; rd_addr = ra;
        cp_valid = cv; cp_addr = ca; cp_data = cd;
        mem_rdata = env_mem[mem_addr[7:0]];
        pre_mw = mem_write; pre_a = mem_addr; pre_d = mem_wdata;
        @(posedge clk);
        if (pre_mw) env_mem[pre_a[7:0]] = pre_d;
        model_edge(rq, ra, cv, ca, cd);
        ncyc++;
        #1;
        chk("mem_read", mem_read, m_mr);
        chk("mem_write", mem_write, m_mw);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wd);
        chk("rd_valid", rd_valid, m_rv);
        if (m_rv) chk("rd_data", rd_data, m_rd);
        chk("rd_late", rd_late, m_late);
        chk("fifo_count", fifo_count, mq.size());
        chk("cp_ready", cp_ready, mq.size() < DEPTH);
        chk("busy", busy, (mq.size() != 0) || m_pend || m_mr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rd_req = 0; rd_addr = '0; cp_valid = 0; cp_addr = '0; cp_data = '0;
        model_reset();
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_late", rd_late, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_cp_ready", cp_ready, 1);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic vec_t mk(
        input bit rq, input logic [19:0] ra, input bit cv,
        input logic [19:0] ca, input logic [7:0] cd,
        input bit mr, input bit mw, input logic [19:0] a,
        input logic [7:0] wd, input int cnt, input bit rdy,
        input bit rv, input logic [7:0] rd, input bit late);
        vec_t v;
        v.rq = rq; v.ra = ra; v.cv = cv; v.ca = ca; v.cd = cd;
        v.e_mr = mr; v.e_mw = mw; v.e_a = a; v.e_wd = wd;
        v.e_cnt = cnt; v.e_rdy = rdy; v.e_rv = rv; v.e_rd = rd;
        v.e_late = late;
        return v;
    endfunction

    initial begin
        vec_t vt[12];
        int nw, nl, wi, li, nrv, nmr, nmw;

        for (int i = 0; i < 256; i++) begin
            env_mem[i] = f_init(20'(i));
            ref_mem[i] = f_init(20'(i));
        end
        model_reset();
        do_reset();

        // fill to full behind reads, reject push when full, drain in order
        vt[0]  = mk(1, 'h10, 1, 'h40, 'h30, 1, 0, 'h10, 0, 1, 1, 0, 0, 0);
        vt[1]  = mk(1, 'h11, 1, 'h41, 'h31, 1, 0, 'h11, 0, 2, 1, 1,
                    f_init('h10), 0);
        vt[2]  = mk(0, 'h00, 1, 'h42, 'h32, 0, 1, 'h40, 'h30, 2, 1, 1,
                    f_init('h11), 0);
        vt[3]  = mk(1, 'h13, 1, 'h43, 'h33, 1, 0, 'h13, 0, 3, 1, 0, 0, 0);
        vt[4]  = mk(1, 'h14, 1, 'h44, 'h34, 1, 0, 'h14, 0, 4, 0, 1,
                    f_init('h13), 0);
        vt[5]  = mk(0, 'h00, 1, 'h45, 'h35, 0, 1, 'h41, 'h31, 3, 1, 1,
                    f_init('h14), 0);
        vt[6]  = mk(0, 'h00, 0, 'h00, 'h00, 0, 1, 'h42, 'h32, 2, 1, 0, 0, 0);
        vt[7]  = mk(0, 'h00, 0, 'h00, 'h00, 0, 1, 'h43, 'h33, 1, 1, 0, 0, 0);
        vt[8]  = mk(0, 'h00, 0, 'h00, 'h00, 0, 1, 'h44, 'h34, 0, 1, 0, 0, 0);
        vt[9]  = mk(0, 'h00, 0, 'h00, 'h00, 0, 0, 'h44, 0, 0, 1, 0, 0, 0);
        vt[10] = mk(1, 'h41, 0, 'h00, 'h00, 1, 0, 'h41, 0, 0, 1, 0, 0, 0);
        vt[11] = mk(0, 'h00, 0, 'h00, 'h00, 0, 0, 'h41, 0, 0, 1, 1, 'h31, 0);
        foreach (vt[k]) begin
            cyc(vt[k].rq, vt[k].ra, vt[k].cv, vt[k].ca, vt[k].cd);
            chk($sformatf("tbl%0d_mr", k), mem_read, vt[k].e_mr);
            chk($sformatf("tbl%0d_mw", k), mem_write, vt[k].e_mw);
            chk($sformatf("tbl%0d_addr", k), mem_addr, vt[k].e_a);
            if (vt[k].e_mw) chk($sformatf("tbl%0d_wd", k), mem_wdata, vt[k].e_wd);
            chk($sformatf("tbl%0d_cnt", k), fifo_count, vt[k].e_cnt);
            chk($sformatf("tbl%0d_rdy", k), cp_ready, vt[k].e_rdy);
            chk($sformatf("tbl%0d_rv", k), rd_valid, vt[k].e_rv);
            if (vt[k].e_rv) chk($sformatf("tbl%0d_rd", k), rd_data, vt[k].e_rd);
            chk($sformatf("tbl%0d_late", k), rd_late, vt[k].e_late);
        end

        // starvation: one queued write under continuous reads
        do_reset();
        nw = 0; nl = 0; wi = -1; li = -1; nrv = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1, 20'(32'h20 + i), i == 0, 20'h60, 8'h77);
            if (mem_write) begin nw++; wi = i; end
            if (rd_late) begin nl++; li = i; end
            if (rd_valid) nrv++;
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 0, '0, '0);
            if (mem_write) nw++;
            if (rd_late) nl++;
            if (rd_valid) nrv++;
        end
        chk("starve_nwrites", nw, 1);
        chk("starve_write_cycle", wi, LIM + 1);
        chk("starve_nlate", nl, 1);
        chk("starve_late_cycle", li, LIM + 1);
        chk("starve_reads_delivered", nrv, 15);

        // reads only, every second cycle
        nmr = 0; nrv = 0;
        for (int i = 0; i < 35; i++) begin
            cyc(i < 32 && i % 2 == 0, 20'(16 + i / 2), 0, '0, '0);
            if (mem_read) nmr++;
            if (rd_valid) nrv++;
        end
        chk("rdonly_mem_read", nmr, 16);
        chk("rdonly_rd_valid", nrv, 16);

        // writes only, back to back
        nmw = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, '0, i < 6, 20'(32'h50 + i), 8'(32'h90 + i));
            if (mem_write) nmw++;
        end
        cyc(0, '0, 0, '0, '0);
        chk("wronly_count", nmw, 6);
        chk("wronly_fifo_empty", fifo_count, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("wronly_mem%0d", i), env_mem[8'h50 + i], 8'h90 + i);
        end

        // reset with queued writes and a read in flight
        for (int i = 0; i < 3; i++) begin
            cyc(1, 20'(32'h30 + i), 1, 20'(32'h70 + i), 8'(32'hC0 + i));
        end
        chk("inflight_pre_cnt", fifo_count, 3);
        do_reset();
        nrv = 0; nmw = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 0, '0, '0);
            if (rd_valid) nrv++;
            if (mem_write) nmw++;
        end
        chk("postrst_rd_valid", nrv, 0);
        chk("postrst_mem_write", nmw, 0);
        chk("postrst_cnt", fifo_count, 0);
        chk("postrst_ready", cp_ready, 1);
        chk("postrst_mem70", env_mem[8'h70], f_init(20'h70));

        // mixed random traffic on a small address window
        for (int i = 0; i < 600; i++) begin
            bit rq;
            rq = (i < 300) ? ($urandom_range(0, 1) == 1)
                           : ($urandom_range(0, 7) != 0);
            cyc(rq, 20'(32'h80 + $urandom_range(0, 7)),
                $urandom_range(0, 2) != 0,
                20'(32'h80 + $urandom_range(0, 7)), 8'($urandom));
        end
        for (int i = 0; i < 12; i++) cyc(0, '0, 0, '0, '0);
        chk("rand_drained", fifo_count, 0);
        chk("rand_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
